// File: rtl/audio_i2s_stream.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_stream
// Purpose  : Stereo serial-audio port for the WM8731 codec path. The codec
//            masters BCLK/ADCLRC/DACLRC; this block oversamples them in the
//            clk_clk domain, deserialises ADC frames into an ADC FIFO and
//            serialises frames from a DAC FIFO onto DACDAT. Both FIFOs sit
//            behind valid/ready streams. I2S or left-justified framing.
// Ports    :
//   clk_clk        system clock (>= 8x BCLK)
//   reset_reset_n  asynchronous active-low reset (released synchronously)
//   audio_BCLK     codec bit clock (asynchronous)
//   audio_ADCLRC   ADC word select, 0 = left, 1 = right
//   audio_ADCDAT   ADC serial data
//   audio_DACLRC   DAC word select, 0 = left, 1 = right
//   audio_DACDAT   DAC serial data (registered)
//   adc_data       ADC FIFO head frame {L,R}, zero while empty
//   adc_valid      ADC FIFO not empty
//   adc_ready      consumer pop strobe (pop when adc_valid & adc_ready)
//   dac_data       playback frame {L,R}
//   dac_valid      producer offers a frame
//   dac_ready      DAC FIFO not full
//   adc_level      ADC FIFO occupancy 0..FIFO_DEPTH
//   dac_level      DAC FIFO occupancy 0..FIFO_DEPTH
//   adc_overflow   sticky: completed ADC frame dropped, FIFO full
//   dac_underflow  sticky: DAC frame start found FIFO empty
//   clear_flags    one-cycle pulse clearing both sticky flags
// Revision : 1.0  initial release
// ============================================================================
module audio_i2s_stream #(
  parameter  int DATA_W     = 24,
  parameter  int FIFO_DEPTH = 16,
  parameter  bit LJ_MODE    = 1'b0,
  localparam int C_AW       = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  audio_BCLK,
  input  logic                  audio_ADCLRC,
  input  logic                  audio_ADCDAT,
  input  logic                  audio_DACLRC,
  output logic                  audio_DACDAT,
  output logic [2*DATA_W-1:0]   adc_data,
  output logic                  adc_valid,
  input  logic                  adc_ready,
  input  logic [2*DATA_W-1:0]   dac_data,
  input  logic                  dac_valid,
  output logic                  dac_ready,
  output logic [C_AW:0]         adc_level,
  output logic [C_AW:0]         dac_level,
  output logic                  adc_overflow,
  output logic                  dac_underflow,
  input  logic                  clear_flags
);

  localparam int              C_FW    = 2 * DATA_W;
  localparam logic [DATA_W-1:0] C_MSB = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [C_AW:0]   C_DEPTH = (C_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT_LEFT = 2'd0,
    ST_LEFT      = 2'd1,
    ST_RIGHT     = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Reset: asserted asynchronously, released on a clock edge.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Input synchronisers. All four codec inputs share the same two-flop depth
  // so data and word-select remain aligned to the synced BCLK edges.
  // --------------------------------------------------------------------------
  logic [1:0] r_bclk_sync;
  logic [1:0] r_adclrc_sync;
  logic [1:0] r_adcdat_sync;
  logic [1:0] r_daclrc_sync;
  logic       r_bclk_prev;
  logic       w_bclk_rise;
  logic       w_bclk_fall;

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bclk_sync   <= 2'b00;
      r_adclrc_sync <= 2'b00;
      r_adcdat_sync <= 2'b00;
      r_daclrc_sync <= 2'b00;
      r_bclk_prev   <= 1'b0;
    end else begin
      r_bclk_sync   <= {r_bclk_sync[0],   audio_BCLK};
      r_adclrc_sync <= {r_adclrc_sync[0], audio_ADCLRC};
      r_adcdat_sync <= {r_adcdat_sync[0], audio_ADCDAT};
      r_daclrc_sync <= {r_daclrc_sync[0], audio_DACLRC};
      r_bclk_prev   <= r_bclk_sync[1];
    end
  end

  assign w_bclk_rise =  r_bclk_sync[1] & ~r_bclk_prev;
  assign w_bclk_fall = ~r_bclk_sync[1] &  r_bclk_prev;

  // --------------------------------------------------------------------------
  // ADC framer (BCLK rise). r_adc_mask is a one-hot pointer to the next bit
  // position to fill; it reaches zero once DATA_W bits are in, after which
  // extra bits are ignored. The word register is cleared at word start, so
  // a word cut short by an LRC edge is already left-aligned and zero-padded.
  // --------------------------------------------------------------------------
  state_t              r_adc_state;
  logic                r_adc_lrc_prev;
  logic [DATA_W-1:0]   r_adc_sr;
  logic [DATA_W-1:0]   r_adc_mask;
  logic [DATA_W-1:0]   r_adc_left;
  logic                r_adc_pushed;

  logic                w_adc_lrc;
  logic                w_adc_bit;
  logic                w_adc_edge;
  logic                w_adc_start;
  logic [DATA_W-1:0]   w_adc_cap_sr;
  logic [DATA_W-1:0]   w_adc_cap_mask;
  logic                w_adc_push;
  logic [C_FW-1:0]     w_adc_push_data;

  assign w_adc_lrc      = r_adclrc_sync[1];
  assign w_adc_bit      = r_adcdat_sync[1];
  assign w_adc_edge     = w_adc_lrc ^ r_adc_lrc_prev;
  // Right-going edges are ignored until the first left edge has been seen.
  assign w_adc_start    = w_adc_edge & ((r_adc_state != ST_WAIT_LEFT) | ~w_adc_lrc);
  assign w_adc_cap_sr   = r_adc_sr | (r_adc_mask & {DATA_W{w_adc_bit}});
  assign w_adc_cap_mask = r_adc_mask >> 1;

  // The frame is pushed when the right word closes: either its last bit is
  // captured or the next left edge cuts it short, whichever comes first.
  always_comb begin
    w_adc_push      = 1'b0;
    w_adc_push_data = {r_adc_left, r_adc_sr};
    if (w_bclk_rise && (r_adc_state == ST_RIGHT) && !r_adc_pushed) begin
      if (w_adc_edge && !w_adc_lrc) begin
        w_adc_push      = 1'b1;
        w_adc_push_data = {r_adc_left, r_adc_sr};
      end else if (!w_adc_edge && (r_adc_mask != '0) && (w_adc_cap_mask == '0)) begin
        w_adc_push      = 1'b1;
        w_adc_push_data = {r_adc_left, w_adc_cap_sr};
      end
    end
  end

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_adc_state    <= ST_WAIT_LEFT;
      r_adc_lrc_prev <= 1'b0;
      r_adc_sr       <= '0;
      r_adc_mask     <= '0;
      r_adc_left     <= '0;
      r_adc_pushed   <= 1'b0;
    end else if (w_bclk_rise) begin
      r_adc_lrc_prev <= w_adc_lrc;
      if (w_adc_push) r_adc_pushed <= 1'b1;
      if (w_adc_start) begin
        if (w_adc_lrc) begin
          r_adc_state <= ST_RIGHT;
          r_adc_left  <= r_adc_sr;
        end else begin
          r_adc_state <= ST_LEFT;
        end
        r_adc_pushed <= 1'b0;
        if (LJ_MODE) begin
          // MSB is on the edge itself.
          r_adc_sr   <= C_MSB & {DATA_W{w_adc_bit}};
          r_adc_mask <= C_MSB >> 1;
        end else begin
          // I2S: the edge rise carries the previous word's trailing bit.
          r_adc_sr   <= '0;
          r_adc_mask <= C_MSB;
        end
      end else if (r_adc_state != ST_WAIT_LEFT) begin
        r_adc_sr   <= w_adc_cap_sr;
        r_adc_mask <= w_adc_cap_mask;
      end
    end
  end

  // --------------------------------------------------------------------------
  // ADC FIFO, first-word fall-through. A push while full is still taken when
  // a pop frees the slot in the same cycle.
  // --------------------------------------------------------------------------
  logic [C_FW-1:0] r_adc_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_adc_wr;
  logic [C_AW-1:0] r_adc_rd;
  logic [C_AW:0]   r_adc_level;
  logic            r_adc_overflow;
  logic            w_adc_full;
  logic            w_adc_pop;
  logic            w_adc_wr_en;

  assign w_adc_full  = (r_adc_level == C_DEPTH);
  assign adc_valid   = (r_adc_level != '0);
  assign w_adc_pop   = adc_valid & adc_ready;
  assign w_adc_wr_en = w_adc_push & (~w_adc_full | w_adc_pop);

  always_ff @(posedge clk_clk) begin
    if (w_adc_wr_en) r_adc_mem[r_adc_wr] <= w_adc_push_data;
  end

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_adc_wr       <= '0;
      r_adc_rd       <= '0;
      r_adc_level    <= '0;
      r_adc_overflow <= 1'b0;
    end else begin
      if (w_adc_wr_en) r_adc_wr <= r_adc_wr + 1'b1;
      if (w_adc_pop)   r_adc_rd <= r_adc_rd + 1'b1;
      case ({w_adc_wr_en, w_adc_pop})
        2'b10:   r_adc_level <= r_adc_level + 1'b1;
        2'b01:   r_adc_level <= r_adc_level - 1'b1;
        default: r_adc_level <= r_adc_level;
      endcase
      // Set wins over a simultaneous clear.
      if (w_adc_push && w_adc_full && !w_adc_pop) r_adc_overflow <= 1'b1;
      else if (clear_flags)                       r_adc_overflow <= 1'b0;
    end
  end

  assign adc_data     = adc_valid ? r_adc_mem[r_adc_rd] : '0;
  assign adc_level    = r_adc_level;
  assign adc_overflow = r_adc_overflow;

  // --------------------------------------------------------------------------
  // DAC FIFO. The framer pops one frame per left edge.
  // --------------------------------------------------------------------------
  logic [C_FW-1:0] r_dac_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_dac_wr;
  logic [C_AW-1:0] r_dac_rd;
  logic [C_AW:0]   r_dac_level;
  logic            r_dac_underflow;
  logic            w_dac_full;
  logic            w_dac_empty;
  logic            w_dac_wr_en;
  logic            w_dac_pop;
  logic            w_dac_left_edge;

  assign w_dac_full  = (r_dac_level == C_DEPTH);
  assign w_dac_empty = (r_dac_level == '0);
  assign dac_ready   = ~w_dac_full;
  assign w_dac_wr_en = dac_valid & ~w_dac_full;
  assign w_dac_pop   = w_dac_left_edge & ~w_dac_empty;

  always_ff @(posedge clk_clk) begin
    if (w_dac_wr_en) r_dac_mem[r_dac_wr] <= dac_data;
  end

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dac_wr        <= '0;
      r_dac_rd        <= '0;
      r_dac_level     <= '0;
      r_dac_underflow <= 1'b0;
    end else begin
      if (w_dac_wr_en) r_dac_wr <= r_dac_wr + 1'b1;
      if (w_dac_pop)   r_dac_rd <= r_dac_rd + 1'b1;
      case ({w_dac_wr_en, w_dac_pop})
        2'b10:   r_dac_level <= r_dac_level + 1'b1;
        2'b01:   r_dac_level <= r_dac_level - 1'b1;
        default: r_dac_level <= r_dac_level;
      endcase
      if (w_dac_left_edge && w_dac_empty) r_dac_underflow <= 1'b1;
      else if (clear_flags)               r_dac_underflow <= 1'b0;
    end
  end

  assign dac_level     = r_dac_level;
  assign dac_underflow = r_dac_underflow;

  // --------------------------------------------------------------------------
  // DAC framer (BCLK fall). The whole frame is latched at the left edge so
  // the right word plays the R half of the same frame. The shift register
  // fills with zeros, so bits after the LSB come out as 0 automatically.
  // --------------------------------------------------------------------------
  state_t            r_dac_state;
  logic              r_dac_lrc_prev;
  logic [C_FW-1:0]   r_dac_frame;
  logic [DATA_W-1:0] r_dac_sr;
  logic              r_dacdat;

  logic              w_dac_lrc;
  logic              w_dac_edge;
  logic              w_dac_start;
  logic [C_FW-1:0]   w_dac_frame_new;
  logic [DATA_W-1:0] w_dac_word;

  assign w_dac_lrc       = r_daclrc_sync[1];
  assign w_dac_edge      = w_dac_lrc ^ r_dac_lrc_prev;
  assign w_dac_left_edge = w_bclk_fall & w_dac_edge & ~w_dac_lrc;
  assign w_dac_start     = w_dac_edge & ((r_dac_state != ST_WAIT_LEFT) | ~w_dac_lrc);

  always_comb begin
    w_dac_frame_new = w_dac_empty ? '0 : r_dac_mem[r_dac_rd];
    w_dac_word      = w_dac_lrc ? r_dac_frame[DATA_W-1:0]
                                : w_dac_frame_new[C_FW-1:DATA_W];
  end

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dac_state    <= ST_WAIT_LEFT;
      r_dac_lrc_prev <= 1'b0;
      r_dac_frame    <= '0;
      r_dac_sr       <= '0;
      r_dacdat       <= 1'b0;
    end else if (w_bclk_fall) begin
      r_dac_lrc_prev <= w_dac_lrc;
      if (w_dac_start) begin
        r_dac_state <= w_dac_lrc ? ST_RIGHT : ST_LEFT;
        if (!w_dac_lrc) r_dac_frame <= w_dac_frame_new;
        if (LJ_MODE) begin
          r_dacdat <= w_dac_word[DATA_W-1];
          r_dac_sr <= {w_dac_word[DATA_W-2:0], 1'b0};
        end else begin
          // I2S: one BCLK of delay before the MSB.
          r_dacdat <= 1'b0;
          r_dac_sr <= w_dac_word;
        end
      end else if (r_dac_state != ST_WAIT_LEFT) begin
        r_dacdat <= r_dac_sr[DATA_W-1];
        r_dac_sr <= {r_dac_sr[DATA_W-2:0], 1'b0};
      end else begin
        r_dacdat <= 1'b0;
      end
    end
  end

  assign audio_DACDAT = r_dacdat;

endmodule
`default_nettype wire
